// File: rtl/cordic_vec_pipe.sv
// Pipelined vectoring-mode CORDIC: converts a Cartesian (x, y) pair into
// atan2 angle and magnitude, one stage per micro-rotation, new launch every 2 cycles.
module cordic_vec_pipe #(
  parameter int NUM_WIDTH = 24,
  parameter int STAGE_CNT = 19
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        data_loaded,
  input  logic signed [NUM_WIDTH-1:0] x_in,
  input  logic signed [NUM_WIDTH-1:0] y_in,
  output logic signed [NUM_WIDTH-1:0] angle,
  output logic signed [NUM_WIDTH-1:0] magnitude,
  output logic                        data_computed
);

  localparam int FRAC_W = NUM_WIDTH - 4;
  // Constants are authored in Q4.20 and widened when NUM_WIDTH > 24.
  localparam int SCL = FRAC_W - 20;
  localparam int MSB = NUM_WIDTH - 1;

  localparam logic signed [NUM_WIDTH-1:0] PI =
    NUM_WIDTH'(24'sb0011_00100100001111110111) <<< SCL;
  localparam logic signed [NUM_WIDTH-1:0] CORDIC_RATIO =
    NUM_WIDTH'(24'sb0000_10011011011101001110) <<< SCL;

  function automatic logic signed [NUM_WIDTH-1:0] atan_entry(input int i);
    logic signed [23:0] t;
    case (i)
      0:  t = 24'sb0000_11001001000011111101;
      1:  t = 24'sd486170;
      2:  t = 24'sd256879;
      3:  t = 24'sd130396;
      4:  t = 24'sd65451;
      5:  t = 24'sd32757;
      6:  t = 24'sd16383;
      7:  t = 24'sd8192;
      8:  t = 24'sd4096;
      9:  t = 24'sd2048;
      10: t = 24'sd1024;
      11: t = 24'sd512;
      12: t = 24'sd256;
      13: t = 24'sd128;
      14: t = 24'sd64;
      15: t = 24'sd32;
      16: t = 24'sd16;
      17: t = 24'sd8;
      18: t = 24'sd4;
      19: t = 24'sd2;
      default: t = 24'sd0;
    endcase
    return NUM_WIDTH'(t) <<< SCL;
  endfunction

  // Truncating gain compensation: keep the integer-aligned window of x * K.
  function automatic logic signed [NUM_WIDTH-1:0] scale_trunc(
    input logic signed [NUM_WIDTH-1:0] x
  );
    logic signed [2*NUM_WIDTH-1:0] prod;
    prod = (2*NUM_WIDTH)'(x) * (2*NUM_WIDTH)'(CORDIC_RATIO);
    return NUM_WIDTH'(prod >>> FRAC_W);
  endfunction

  logic                        dl_q;
  logic                        launch;
  logic signed [NUM_WIDTH-1:0] x_pre;
  logic signed [NUM_WIDTH-1:0] y_pre;
  logic signed [NUM_WIDTH-1:0] z_pre;

  logic signed [NUM_WIDTH-1:0] x_p [0:STAGE_CNT];
  logic signed [NUM_WIDTH-1:0] y_p [0:STAGE_CNT];
  logic signed [NUM_WIDTH-1:0] z_p [0:STAGE_CNT];
  logic        [STAGE_CNT:0]   zero_p;
  logic        [STAGE_CNT:0]   vld_p;

  logic signed [NUM_WIDTH-1:0] ang_ps;
  logic signed [NUM_WIDTH-1:0] mag_ps;
  logic                        vld_ps;

  assign launch = data_loaded & ~dl_q;

  // Left half-plane inputs are rotated by pi so the iterations only cover +/- pi/2.
  always_comb begin
    if (!x_in[MSB]) begin
      x_pre = x_in;
      y_pre = y_in;
      z_pre = '0;
    end else begin
      x_pre = -x_in;
      y_pre = -y_in;
      z_pre = y_in[MSB] ? -PI : PI;
    end
  end

  always_ff @(posedge clk) begin
    // stage P: pre-rotation, loaded only on a launch edge
    if (launch) begin
      x_p[0]    <= x_pre;
      y_p[0]    <= y_pre;
      z_p[0]    <= z_pre;
      zero_p[0] <= (x_in == '0) && (y_in == '0);
    end
    // stages 0..STAGE_CNT-1: micro-rotations driving y toward zero
    for (int i = 0; i < STAGE_CNT; i++) begin
      if (!y_p[i][MSB]) begin
        x_p[i+1] <= x_p[i] + (y_p[i] >>> i);
        y_p[i+1] <= y_p[i] - (x_p[i] >>> i);
        z_p[i+1] <= z_p[i] + atan_entry(i);
      end else begin
        x_p[i+1] <= x_p[i] - (y_p[i] >>> i);
        y_p[i+1] <= y_p[i] + (x_p[i] >>> i);
        z_p[i+1] <= z_p[i] - atan_entry(i);
      end
      zero_p[i+1] <= zero_p[i];
    end
    // scale stage: the zero vector has no direction, so its angle is forced to 0
    ang_ps <= zero_p[STAGE_CNT] ? '0 : z_p[STAGE_CNT];
    mag_ps <= scale_trunc(x_p[STAGE_CNT]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dl_q          <= 1'b1;
      vld_p         <= '0;
      vld_ps        <= 1'b0;
      data_computed <= 1'b0;
      angle         <= '0;
      magnitude     <= '0;
    end else begin
      dl_q          <= data_loaded;
      vld_p         <= {vld_p[STAGE_CNT-1:0], launch};
      vld_ps        <= vld_p[STAGE_CNT];
      // output stage: results only move when a valid operation arrives
      data_computed <= vld_ps;
      if (vld_ps) begin
        angle     <= ang_ps;
        magnitude <= mag_ps;
      end
    end
  end

endmodule

// File: tb/tb_cordic_vec_pipe.sv
// Bench for cordic_vec_pipe: real-arithmetic atan2/hypot model with launch queue,
// per-cycle output compare, directed literal cases, bursts, and reset scenarios.
`timescale 1ns/1ps
module tb_cordic_vec_pipe;
  localparam int  NUM_WIDTH = 24;
  localparam int  STAGE_CNT = 19;
  localparam int  LAT       = STAGE_CNT + 3;
  localparam int  TOL       = 32;
  localparam int  PI_Q      = 3294199;
  localparam real TWO_PI_Q  = 2.0 * 3.14159265358979323846 * 1048576.0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic data_loaded = 1'b0;
  logic signed [NUM_WIDTH-1:0] x_in = '0;
  logic signed [NUM_WIDTH-1:0] y_in = '0;
  logic signed [NUM_WIDTH-1:0] angle;
  logic signed [NUM_WIDTH-1:0] magnitude;
  logic data_computed;

  int pass_cnt = 0;
  int total_cnt = 0;
  int pulse_cnt = 0;

  typedef struct { int ang; int mag; int due; } exp_t;
  exp_t q[$];
  int   edge_n = 0;
  bit   prev_dl = 1'b1;
  int   held_a = 0;
  int   held_m = 0;

  cordic_vec_pipe #(.NUM_WIDTH(NUM_WIDTH), .STAGE_CNT(STAGE_CNT)) dut (
    .clk(clk),
    .rst(rst),
    .data_loaded(data_loaded),
    .x_in(x_in),
    .y_in(y_in),
    .angle(angle),
    .magnitude(magnitude),
    .data_computed(data_computed)
  );

  always #5 clk = ~clk;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int model_angle(input int x, input int y);
    if (x == 0 && y == 0) return 0;
    return int'($atan2(real'(y), real'(x)) * 1048576.0);
  endfunction

  function automatic int model_mag(input int x, input int y);
    return int'($sqrt(real'(x) * real'(x) + real'(y) * real'(y)));
  endfunction

  // Angle distance on the circle, so +pi and -pi are treated as neighbours.
  function automatic int ang_err(input int act, input int req);
    real d;
    d = real'(act) - real'(req);
    if (d > real'(PI_Q)) d = d - TWO_PI_Q;
    if (d < -real'(PI_Q)) d = d + TWO_PI_Q;
    return iabs(int'(d));
  endfunction

  function automatic int mag_tol(input int req);
    return TOL + iabs(req) / 131072;
  endfunction

  task automatic check(input string name, input bit ok, input int act, input int req);
    total_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Reference: every launch edge queues its expected result and the edge it must appear after.
  always @(posedge clk) begin
    exp_t e;
    bit   due;
    edge_n++;
    if (rst) begin
      q.delete();
      prev_dl = 1'b1;
      held_a  = 0;
      held_m  = 0;
    end else begin
      if (data_loaded && !prev_dl) begin
        e.ang = model_angle(int'(x_in), int'(y_in));
        e.mag = model_mag(int'(x_in), int'(y_in));
        e.due = edge_n + STAGE_CNT + 2;
        q.push_back(e);
      end
      prev_dl = data_loaded;
    end
    #1;
    if (data_computed) pulse_cnt++;
    due = (q.size() > 0) && (q[0].due == edge_n);
    check("data_computed", data_computed == due, int'(data_computed), int'(due));
    if (due) begin
      check("angle", ang_err(int'(angle), q[0].ang) <= TOL, int'(angle), q[0].ang);
      check("magnitude", iabs(int'(magnitude) - q[0].mag) <= mag_tol(q[0].mag),
            int'(magnitude), q[0].mag);
      held_a = q[0].ang;
      held_m = q[0].mag;
      void'(q.pop_front());
    end else begin
      check("angle_hold", ang_err(int'(angle), held_a) <= TOL, int'(angle), held_a);
      check("magnitude_hold", iabs(int'(magnitude) - held_m) <= mag_tol(held_m),
            int'(magnitude), held_m);
    end
  end

  task automatic run_op(input string name, input int x, input int y,
                        output int got_a, output int got_m);
    int  k;
    bit  seen;
    @(negedge clk);
    x_in = x[NUM_WIDTH-1:0];
    y_in = y[NUM_WIDTH-1:0];
    data_loaded = 1'b1;
    seen = 1'b0;
    k = 1;
    while (k <= LAT + 10 && !seen) begin
      @(posedge clk);
      #2;
      if (data_computed) seen = 1'b1;
      else k++;
    end
    check({name, "_latency"}, seen && (k == LAT), k, LAT);
    got_a = int'(angle);
    got_m = int'(magnitude);
    @(negedge clk);
    data_loaded = 1'b0;
    @(negedge clk);
  endtask

  task automatic gen_vec(output int x, output int y);
    real r2;
    do begin
      x = int'($urandom_range(0, 6291456)) - 3145728;
      y = int'($urandom_range(0, 6291456)) - 3145728;
      r2 = real'(x) * real'(x) + real'(y) * real'(y);
    end while (r2 < 2.25 * 1099511627776.0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a, m, pc0, rx, ry, hi, gap;
    int bx[3];
    int by[3];

    check("model_east", model_angle(1048576, 0) == 0, model_angle(1048576, 0), 0);
    check("model_north", model_angle(0, 1048576) == 32'h1921FB, model_angle(0, 1048576), 32'h1921FB);
    check("model_west", model_angle(-1048576, 0) == 32'h3243F7, model_angle(-1048576, 0), 32'h3243F7);
    check("model_diag_mag", model_mag(1048576, -1048576) == 32'h16A09E,
          model_mag(1048576, -1048576), 32'h16A09E);

    repeat (3) @(negedge clk);
    check("reset_angle", angle == '0, int'(angle), 0);
    check("reset_mag", magnitude == '0, int'(magnitude), 0);
    check("reset_pulse", data_computed == 1'b0, int'(data_computed), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_op("east", 32'h100000, 0, a, m);
    check("east_angle", iabs(a) <= TOL, a, 0);
    check("east_mag", iabs(m - 32'h100000) <= TOL, m, 32'h100000);
    run_op("north", 0, 32'h100000, a, m);
    check("north_angle", iabs(a - 32'h1921FB) <= TOL, a, 32'h1921FB);
    check("north_mag", iabs(m - 32'h100000) <= TOL, m, 32'h100000);
    run_op("west", -32'h100000, 0, a, m);
    check("west_angle", iabs(a - 32'h3243F7) <= TOL, a, 32'h3243F7);
    run_op("west_low", -32'h100000, -1, a, m);
    check("west_low_angle", (a < 0) && (iabs(a + 32'h3243F7) <= TOL), a, -32'h3243F7);
    run_op("diag", 32'h100000, -32'h100000, a, m);
    check("diag_angle", iabs(a + 32'h0C90FE) <= TOL, a, -32'h0C90FE);
    check("diag_mag", iabs(m - 32'h16A09E) <= TOL, m, 32'h16A09E);
    run_op("zero", 0, 0, a, m);
    check("zero_angle", a == 0, a, 0);
    check("zero_mag", m == 0, m, 0);

    bx[0] = 32'h200000;  by[0] = 32'h100000;
    bx[1] = -32'h180000; by[1] = 32'h080000;
    bx[2] = 32'h080000;  by[2] = -32'h280000;
    pc0 = pulse_cnt;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      x_in = bx[j][NUM_WIDTH-1:0];
      y_in = by[j][NUM_WIDTH-1:0];
      data_loaded = 1'b1;
      @(negedge clk);
      data_loaded = 1'b0;
      x_in = NUM_WIDTH'($urandom);
      y_in = NUM_WIDTH'($urandom);
    end
    repeat (LAT + 4) @(negedge clk);
    check("burst_pulses", pulse_cnt - pc0 == 3, pulse_cnt - pc0, 3);

    pc0 = pulse_cnt;
    @(negedge clk);
    x_in = 24'h100000;
    y_in = 24'h100000;
    data_loaded = 1'b1;
    repeat (10) @(negedge clk);
    data_loaded = 1'b0;
    repeat (LAT + 4) @(negedge clk);
    check("held_high_pulses", pulse_cnt - pc0 == 1, pulse_cnt - pc0, 1);

    pc0 = pulse_cnt;
    @(negedge clk);
    x_in = 24'h180000;
    y_in = 24'hE80000;
    data_loaded = 1'b1;
    @(negedge clk);
    data_loaded = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    data_loaded = 1'b1;
    #1;
    check("async_rst_angle", angle == '0, int'(angle), 0);
    check("async_rst_mag", magnitude == '0, int'(magnitude), 0);
    check("async_rst_pulse", data_computed == 1'b0, int'(data_computed), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (LAT + 10) @(negedge clk);
    check("rst_no_pulse", pulse_cnt == pc0, pulse_cnt - pc0, 0);
    data_loaded = 1'b0;
    @(negedge clk);
    run_op("post_rst", 32'h100000, 0, a, m);
    check("post_rst_mag", iabs(m - 32'h100000) <= TOL, m, 32'h100000);

    for (int n = 0; n < 300; n++) begin
      gen_vec(rx, ry);
      @(negedge clk);
      x_in = rx[NUM_WIDTH-1:0];
      y_in = ry[NUM_WIDTH-1:0];
      data_loaded = 1'b1;
      hi = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 4)) : 1;
      repeat (hi) begin
        @(negedge clk);
        x_in = NUM_WIDTH'($urandom);
        y_in = NUM_WIDTH'($urandom);
      end
      data_loaded = 1'b0;
      gap = int'($urandom_range(0, 2));
      repeat (gap) begin
        @(negedge clk);
        x_in = NUM_WIDTH'($urandom);
        y_in = NUM_WIDTH'($urandom);
      end
    end
    repeat (LAT + 5) @(negedge clk);
    check("drain", q.size() == 0, q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
